// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder: FSM state encoding, default
// address map and latency, and address decode helpers.
package sram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h8000_0000;
  localparam int          DEFAULT_LATENCY   = 2;

  // Word offset of a byte address from the window base; low two bits dropped.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

  // Unsigned wrap makes addresses below the base look huge, so one compare suffices.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] span_bytes);
    return ((addr - base) < span_bytes);
  endfunction

endpackage

// File: rtl/sram_responder_sram_array.sv
// Single-port word-wide storage with per-byte write enables and a registered
// read port; contents are never cleared by reset.
module sram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    wmask,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read; holds its value until the next read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= 32'd0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Fixed-latency memory-mapped SRAM target with valid/ready request and
// response channels and a single outstanding transaction.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEFAULT_ADDR_BASE,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH * 4);

  state_t         state_r;
  logic [3:0]     cnt_r;
  logic           lat_wen_r;
  logic [31:0]    lat_addr_r;
  logic [31:0]    lat_wdata_r;
  logic [3:0]     lat_wmask_r;

  logic           accept_s;
  logic           commit_s;
  logic           req_in_range_s;
  logic           lat_in_range_s;
  logic [AW-1:0]  req_idx_s;
  logic [AW-1:0]  lat_idx_s;
  logic           mem_en_s;
  logic           mem_we_s;
  logic [AW-1:0]  mem_addr_s;
  logic [31:0]    mem_rdata_s;

  // Address decode and storage port steering: reads are issued at acceptance
  // so the word is waiting by commit time; writes land on the commit edge.
  always_comb begin
    req_in_range_s = addr_in_range(req_addr, ADDR_BASE, SPAN_BYTES);
    lat_in_range_s = addr_in_range(lat_addr_r, ADDR_BASE, SPAN_BYTES);
    req_idx_s      = AW'(word_offset(req_addr, ADDR_BASE));
    lat_idx_s      = AW'(word_offset(lat_addr_r, ADDR_BASE));
    accept_s       = 1'b0;
    commit_s       = 1'b0;
    mem_en_s       = 1'b0;
    mem_we_s       = 1'b0;
    mem_addr_s     = req_idx_s;
    case (state_r)
      ST_IDLE: begin
        accept_s   = req_valid && req_ready;
        mem_en_s   = accept_s && !req_wen && req_in_range_s;
        mem_addr_s = req_idx_s;
      end
      ST_WAIT: begin
        commit_s   = (cnt_r == 4'd0);
        mem_en_s   = commit_s && lat_wen_r && lat_in_range_s;
        mem_we_s   = 1'b1;
        mem_addr_s = lat_idx_s;
      end
      ST_RESP: begin
        mem_en_s   = 1'b0;
      end
      default: begin
        mem_en_s   = 1'b0;
      end
    endcase
  end

  // Request/response FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      lat_wen_r   <= 1'b0;
      lat_addr_r  <= 32'd0;
      lat_wdata_r <= 32'd0;
      lat_wmask_r <= 4'd0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            lat_wen_r   <= req_wen;
            lat_addr_r  <= req_addr;
            lat_wdata_r <= req_wdata;
            lat_wmask_r <= req_wmask;
            cnt_r       <= 4'(LATENCY - 1);
            req_ready   <= 1'b0;
            state_r     <= ST_WAIT;
          end else begin
            req_ready   <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (commit_s) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !lat_in_range_s;
            rsp_rdata <= (!lat_wen_r && lat_in_range_s) ? mem_rdata_s : 32'd0;
            state_r   <= ST_RESP;
          end else begin
            cnt_r     <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en_s),
    .we    (mem_we_s),
    .wmask (lat_wmask_r),
    .addr  (mem_addr_s),
    .wdata (lat_wdata_r),
    .rdata (mem_rdata_s)
  );

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: table of transactions checked
// through a scoreboard queue, plus reset, backpressure and reset-in-WAIT sequences.
module tb_sram_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    string       name;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  txn_t vec[$];
  int   n_checks;
  int   n_fail;

  sram_responder #(
    .ADDR_BASE (32'h8000_0000),
    .DEPTH     (1024),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction; hold > 0 keeps rsp_ready low for that many cycles.
  task automatic run_req(input txn_t t, input int hold);
    bit   accepted;
    bit   got;
    int   lat;
    exp_t e;
    logic [31:0] snap_rdata;
    logic        snap_err;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = t.wen;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_wmask = t.wmask;
    rsp_ready = (hold == 0);
    accepted  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      chk({t.name, "_accept"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb_q.push_back('{rdata: t.exp_rdata, err: t.exp_err});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    if (!got) begin
      chk({t.name, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
      return;
    end
    chk({t.name, "_latency"}, 32'(lat), 32'(LAT));
    e = sb_q.pop_front();
    chk({t.name, "_rdata"}, rsp_rdata, e.rdata);
    chk({t.name, "_err"}, 32'(rsp_err), 32'(e.err));
    chk({t.name, "_ready_busy"}, 32'(req_ready), 32'd0);
    if (hold > 0) begin
      snap_rdata = rsp_rdata;
      snap_err   = rsp_err;
      req_valid  = 1'b1;
      req_wen    = 1'b1;
      req_addr   = 32'h8000_0010;
      req_wdata  = 32'h0000_0000;
      req_wmask  = 4'hF;
      for (int c = 0; c < hold; c++) begin
        @(posedge clk);
        #1;
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rdata", rsp_rdata, snap_rdata);
        chk("bp_err", 32'(rsp_err), 32'(snap_err));
        chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({t.name, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({t.name, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    txn_t t;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_wmask = 4'd0;
    rsp_ready = 1'b1;

    // Reset: outputs quiet while asserted, ready after the first edge out of reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready_after", 32'(req_ready), 32'd1);

    vec.push_back('{"wr_deadbeef", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0});
    vec.push_back('{"rd_deadbeef", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0});
    vec.push_back('{"wr_base", 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 32'd0, 1'b0});
    vec.push_back('{"wr_11223344", 1'b1, 32'h8000_0014, 32'h1122_3344, 4'hF, 32'd0, 1'b0});
    vec.push_back('{"wr_mask0101", 1'b1, 32'h8000_0014, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0});
    vec.push_back('{"rd_masked", 1'b0, 32'h8000_0014, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0});
    vec.push_back('{"wr_mask0", 1'b1, 32'h8000_0016, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0});
    vec.push_back('{"rd_after_mask0", 1'b0, 32'h8000_0014, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0});
    vec.push_back('{"rd_below", 1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 32'd0, 1'b1});
    vec.push_back('{"wr_above", 1'b1, 32'h8000_1000, 32'h5555_5555, 4'hF, 32'd0, 1'b1});
    vec.push_back('{"wr_above_wrap", 1'b1, 32'h8000_1010, 32'h6666_6666, 4'hF, 32'd0, 1'b1});
    vec.push_back('{"rd_base_kept", 1'b0, 32'h8000_0000, 32'd0, 4'h0, 32'h0BAD_F00D, 1'b0});
    vec.push_back('{"rd_w4_kept", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0});
    vec.push_back('{"wr_last", 1'b1, 32'h8000_0FFC, 32'h600D_CAFE, 4'hF, 32'd0, 1'b0});
    vec.push_back('{"rd_last_lowbits", 1'b0, 32'h8000_0FFF, 32'd0, 4'h0, 32'h600D_CAFE, 1'b0});
    vec.push_back('{"wr_prior", 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0});

    foreach (vec[i]) run_req(vec[i], 0);

    // Backpressure on a read; stray requests during RESP must be ignored
    t = '{"bp_rd", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0};
    run_req(t, 6);
    t = '{"bp_rd_err", 1'b0, 32'h9000_0000, 32'd0, 4'h0, 32'd0, 1'b1};
    run_req(t, 6);
    t = '{"rd_after_bp", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0};
    run_req(t, 0);

    // Reset one cycle after accepting a write: the write must be lost
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'h1234_5678;
    req_wmask = 4'hF;
    chk("midwait_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midwait_rst_ready", 32'(req_ready), 32'd0);
    chk("midwait_rst_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("midwait_rst_valid_hold", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midwait_ready_after", 32'(req_ready), 32'd1);
    t = '{"rd_after_rst", 1'b0, 32'h8000_0020, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0};
    run_req(t, 0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
